// File: rtl/rev_demux4_deser_pkg.sv
// Shared constants, mode encoding and lane-strobe helper for the reversible 1:4 deserialiser.
package rev_demux4_deser_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;

  typedef enum logic {
    ModeAuto = 1'b0,
    ModeAddr = 1'b1
  } mode_e;

  function automatic logic [LANES-1:0] onehot4(input logic [LANE_W-1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rev_demux4_deser_if.sv
// Serial-in / lane-out bundle of the reversible 1:4 deserialiser.
interface rev_demux4_deser_if;
  import rev_demux4_deser_pkg::*;

  logic              din;
  logic              din_valid;
  logic              mode;
  logic [LANE_W-1:0] sel;
  logic              clear;
  logic [LANES-1:0]  y;
  logic [LANES-1:0]  lane_strb;
  logic [LANES-1:0]  word;
  logic              word_valid;
  logic [LANE_W-1:0] ptr;

  modport master (
    output din, din_valid, mode, sel, clear,
    input  y, lane_strb, word, word_valid, ptr
  );

  modport slave (
    input  din, din_valid, mode, sel, clear,
    output y, lane_strb, word, word_valid, ptr
  );

endinterface

// File: rtl/rev_demux2.sv
// Reversible 1:2 demux: Fredkin gate with its third input tied to 0.
module rev_demux2 (
  input  logic a,
  input  logic b,
  output logic p,
  output logic q,
  output logic r
);

  assign p = a;
  assign q = ~a & b;
  assign r = a & b;

endmodule

// File: rtl/rev_demux4_deser.sv
// Registered 1:4 serial-to-parallel front end built on a tree of reversible 1:2 demux cells.
module rev_demux4_deser
  import rev_demux4_deser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  rev_demux4_deser_if.slave bus
);

  logic              mode_q;
  logic [LANE_W-1:0] ptr_q;
  logic [LANES-1:0]  lanes_q;
  logic [LANES-1:0]  y_q;
  logic [LANES-1:0]  strb_q;
  logic [LANES-1:0]  word_q;
  logic              word_valid_q;

  logic              mode_chg;
  logic [LANE_W-1:0] ptr_eff;
  logic [LANE_W-1:0] lane;
  logic [LANES-1:0]  lanes_eff;
  logic [LANES-1:0]  lanes_wr;
  logic [LANES-1:0]  routed;
  logic              upper;
  logic              lower;
  logic              s0_chain;
  logic              unused_p_s1;
  logic              unused_p_hi;

  // A mode change restarts assembly before this cycle's write is applied.
  always_comb begin
    mode_chg  = (bus.mode != mode_q);
    ptr_eff   = mode_chg ? '0 : ptr_q;
    lanes_eff = mode_chg ? '0 : lanes_q;
    if (bus.mode == ModeAddr) begin
      lane = bus.sel;
    end else if (MSB_FIRST) begin
      lane = LANE_W'(LANES - 1) - ptr_eff;
    end else begin
      lane = ptr_eff;
    end
    lanes_wr       = lanes_eff;
    lanes_wr[lane] = bus.din;
  end

  // Stage 1 splits on s1; stage 2 splits each branch on s0, with the select
  // passed through the lower cell's p output. Unused p outputs are garbage.
  rev_demux2 u_stage1 (
    .a (lane[1]),
    .b (bus.din),
    .p (unused_p_s1),
    .q (lower),
    .r (upper)
  );

  rev_demux2 u_stage2_lo (
    .a (lane[0]),
    .b (lower),
    .p (s0_chain),
    .q (routed[0]),
    .r (routed[1])
  );

  rev_demux2 u_stage2_hi (
    .a (s0_chain),
    .b (upper),
    .p (unused_p_hi),
    .q (routed[2]),
    .r (routed[3])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= ModeAuto;
      ptr_q        <= '0;
      lanes_q      <= '0;
      y_q          <= '0;
      strb_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      mode_q <= bus.mode;
      if (bus.clear) begin
        ptr_q        <= '0;
        lanes_q      <= '0;
        y_q          <= '0;
        strb_q       <= '0;
        word_valid_q <= 1'b0;
      end else if (bus.din_valid) begin
        y_q          <= routed;
        strb_q       <= onehot4(lane);
        word_valid_q <= 1'b0;
        lanes_q      <= lanes_wr;
        if (bus.mode == ModeAddr) begin
          ptr_q <= ptr_eff;
        end else begin
          ptr_q <= ptr_eff + LANE_W'(1);
          if (ptr_eff == LANE_W'(LANES - 1)) begin
            word_q       <= lanes_wr;
            word_valid_q <= 1'b1;
            lanes_q      <= '0;
          end
        end
      end else begin
        y_q          <= '0;
        strb_q       <= '0;
        word_valid_q <= 1'b0;
        ptr_q        <= ptr_eff;
        lanes_q      <= lanes_eff;
      end
    end
  end

  assign bus.y          = y_q;
  assign bus.lane_strb  = strb_q;
  assign bus.word       = word_q;
  assign bus.word_valid = word_valid_q;
  assign bus.ptr        = ptr_q;

endmodule

// File: tb/tb_rev_demux4_deser.sv
// Bench for rev_demux4_deser: LSB-first and MSB-first instances driven in lockstep.
module tb_rev_demux4_deser;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rev_demux4_deser_if if0 ();
  rev_demux4_deser_if if1 ();

  rev_demux4_deser #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  rev_demux4_deser #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;

  typedef struct {
    logic       din;
    logic       dv;
    logic       mode;
    logic [1:0] sel;
    logic       clr;
    logic [3:0] y;
    logic [3:0] strb;
    logic [3:0] word;
    logic       wv;
    logic [1:0] ptr;
  } vec_t;

  vec_t tbl[$];

  // Reference model: count of bits gathered so far plus a per-lane bit array.
  int         m_cnt  [2];
  logic [3:0] m_bits [2];
  logic [3:0] m_word [2];
  logic [3:0] m_y    [2];
  logic [3:0] m_strb [2];
  logic       m_wv   [2];
  logic       m_prev [2];

  function automatic vec_t mk(input logic din, input logic dv, input logic mode,
                              input logic [1:0] sel, input logic clr, input logic [3:0] y,
                              input logic [3:0] strb, input logic [3:0] word, input logic wv,
                              input logic [1:0] ptr);
    vec_t v;
    v.din = din; v.dv = dv; v.mode = mode; v.sel = sel; v.clr = clr;
    v.y = y; v.strb = strb; v.word = word; v.wv = wv; v.ptr = ptr;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_bits[k] = '0; m_word[k] = '0; m_y[k] = '0;
      m_strb[k] = '0; m_wv[k] = 1'b0; m_prev[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic din, input logic dv, input logic mode,
                            input logic [1:0] sel, input logic clr);
    for (int k = 0; k < 2; k++) begin
      int lane;
      if (mode !== m_prev[k]) begin
        m_cnt[k] = 0; m_bits[k] = '0;
      end
      m_prev[k] = mode;
      if (clr) begin
        m_cnt[k] = 0; m_bits[k] = '0; m_y[k] = '0; m_strb[k] = '0; m_wv[k] = 1'b0;
      end else if (dv) begin
        lane = mode ? int'(sel) : ((k == 1) ? 3 - m_cnt[k] : m_cnt[k]);
        m_bits[k][lane] = din;
        m_strb[k] = 4'(1 << lane);
        m_y[k] = din ? 4'(1 << lane) : 4'b0000;
        m_wv[k] = 1'b0;
        if (!mode) begin
          m_cnt[k]++;
          if (m_cnt[k] == 4) begin
            m_word[k] = m_bits[k]; m_wv[k] = 1'b1; m_bits[k] = '0; m_cnt[k] = 0;
          end
        end
      end else begin
        m_y[k] = '0; m_strb[k] = '0; m_wv[k] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " d0.y"},    if0.y,                     m_y[0]);
    chk({tag, " d0.strb"}, if0.lane_strb,             m_strb[0]);
    chk({tag, " d0.word"}, if0.word,                  m_word[0]);
    chk({tag, " d0.wv"},   {3'b0, if0.word_valid},    {3'b0, m_wv[0]});
    chk({tag, " d0.ptr"},  {2'b0, if0.ptr},           4'(m_cnt[0]));
    chk({tag, " d1.y"},    if1.y,                     m_y[1]);
    chk({tag, " d1.strb"}, if1.lane_strb,             m_strb[1]);
    chk({tag, " d1.word"}, if1.word,                  m_word[1]);
    chk({tag, " d1.wv"},   {3'b0, if1.word_valid},    {3'b0, m_wv[1]});
    chk({tag, " d1.ptr"},  {2'b0, if1.ptr},           4'(m_cnt[1]));
  endtask

  task automatic drive(input logic din, input logic dv, input logic mode,
                       input logic [1:0] sel, input logic clr);
    if0.din = din; if0.din_valid = dv; if0.mode = mode; if0.sel = sel; if0.clear = clr;
    if1.din = din; if1.din_valid = dv; if1.mode = mode; if1.sel = sel; if1.clear = clr;
  endtask

  task automatic cycle(input logic din, input logic dv, input logic mode,
                       input logic [1:0] sel, input logic clr, input string tag);
    drive(din, dv, mode, sel, clr);
    @(posedge clk);
    model_step(din, dv, mode, sel, clr);
    #1;
    check_model(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       cur_mode;
    total = 0; bad = 0;
    clk = 1'b0; rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "post_reset");

    // Auto word, back-to-back words, then addressed writes.
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'b0100, 4'b0100, 4'b0000, 0, 3));
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'b1000, 4'b1000, 4'b1101, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1101, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'b0001, 4'b0001, 4'b1101, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b0010, 4'b1101, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'b0100, 4'b0100, 4'b1101, 0, 3));
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'b1000, 4'b1000, 4'b1101, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b0001, 4'b1101, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'b0010, 4'b0010, 4'b1101, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'b0100, 4'b0100, 4'b1101, 0, 3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b1000, 4'b0110, 1, 0));
    tbl.push_back(mk(1, 1, 1, 2, 0, 4'b0100, 4'b0100, 4'b0110, 0, 0));
    tbl.push_back(mk(0, 1, 1, 3, 0, 4'b0000, 4'b1000, 4'b0110, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0110, 0, 0));
    foreach (tbl[i]) begin
      cycle(tbl[i].din, tbl[i].dv, tbl[i].mode, tbl[i].sel, tbl[i].clr, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.y", i),    if0.y,                  tbl[i].y);
      chk($sformatf("tbl%0d.strb", i), if0.lane_strb,          tbl[i].strb);
      chk($sformatf("tbl%0d.word", i), if0.word,               tbl[i].word);
      chk($sformatf("tbl%0d.wv", i),   {3'b0, if0.word_valid}, {3'b0, tbl[i].wv});
      chk($sformatf("tbl%0d.ptr", i),  {2'b0, if0.ptr},        {2'b0, tbl[i].ptr});
    end

    // Partial auto word discarded by a switch to addressed mode.
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, "t5a");
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, "t5b");
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "t5sw");
    chk("t5sw.ptr",  {2'b0, if0.ptr},        4'd0);
    chk("t5sw.wv",   {3'b0, if0.word_valid}, 4'd0);
    chk("t5sw.word", if0.word,               4'b0110);
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "t5c");
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, "t5d");
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "t5e");
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, "t5f");
    chk("t5f.d0word", if0.word,               4'b1010);
    chk("t5f.d0wv",   {3'b0, if0.word_valid}, 4'd1);
    chk("t5f.d1word", if1.word,               4'b0101);

    // clear coinciding with the 4th bit, then an MSB-first word.
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, "t6a");
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, "t6clr");
    chk("t6clr.wv",   {3'b0, if0.word_valid}, 4'd0);
    chk("t6clr.ptr",  {2'b0, if0.ptr},        4'd0);
    chk("t6clr.word", if0.word,               4'b1010);
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, "t6b");
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "t6c");
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "t6d");
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "t6e");
    chk("t6e.d1word", if1.word,               4'b1000);
    chk("t6e.d1wv",   {3'b0, if1.word_valid}, 4'd1);
    chk("t6e.d0word", if0.word,               4'b0001);

    // Asynchronous reset in the middle of a word with din_valid held high.
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, "pre_rst");
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, "pre_rst");
    drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("async_rst");
    chk("async_rst.d0ptr", {2'b0, if0.ptr}, 4'd0);
    @(posedge clk);
    #1;
    check_model("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "rst_release");

    // Randomised traffic against the model.
    cur_mode = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) cur_mode = ~cur_mode;
      cycle(1'($urandom), ($urandom_range(0, 3) != 0), cur_mode, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 19) == 0), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
